// File: rtl/serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor_ctrl
//  Description : Bit-serial WIDTH-bit subtractor computing a - b, LSB first,
//                reusing one full-subtractor cell across all bit slices.
//                Handshake is start (accepted in IDLE), busy and a one-cycle
//                done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] part;
  logic             borrow;
  logic [CNT_W-1:0] cnt;
  logic             cell_d;
  logic             cell_bo;
  logic             last_bit;

  // The single shared full-subtractor cell, fed from the operand LSBs.
  assign cell_d   = sa[0] ^ sb[0] ^ borrow;
  assign cell_bo  = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  // Handshake outputs decoded purely from the state register.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: capture operands, shift one slice per cycle, publish at the end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sa     <= '0;
      sb     <= '0;
      part   <= '0;
      borrow <= 1'b0;
      cnt    <= '0;
      diff   <= '0;
      bout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa     <= a;
            sb     <= b;
            part   <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          sa     <= {1'b0, sa[WIDTH-1:1]};
          sb     <= {1'b0, sb[WIDTH-1:1]};
          part   <= {cell_d, part[WIDTH-1:1]};
          borrow <= cell_bo;
          cnt    <= cnt + 1'b1;
          // Result registers only move here, so the partial sum never leaks out.
          if (last_bit) begin
            diff <= {cell_d, part[WIDTH-1:1]};
            bout <= cell_bo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_subtractor_ctrl
//  Description : Scoreboard bench for serial_subtractor_ctrl at WIDTH=8 and
//                WIDTH=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_ctrl;

  typedef struct {
    logic [7:0] diff;
    logic       bout;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       start2 = 1'b0;
  logic [1:0] a2 = '0;
  logic [1:0] b2 = '0;
  logic       busy2, done2, bout2;
  logic [1:0] diff2;

  int   cyc = 0;
  int   vectors = 0;
  int   errs = 0;
  exp_t q8[$];
  exp_t q2[$];

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
  );

  serial_subtractor_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
    .busy(busy2), .done(done2), .diff(diff2), .bout(bout2)
  );

  always #5 clk = ~clk;

  // Edge counter: value N means N rising edges have occurred.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor for a result port: pops on done, flags unexpected or missing done.
  task automatic monitor(input int w);
    exp_t e;
    logic d;
    logic [7:0] df;
    logic bo;
    forever begin
      @(negedge clk);
      if (w == 8) begin d = done8; df = diff8; bo = bout8; end
      else        begin d = done2; df = {6'b0, diff2}; bo = bout2; end
      if (!rst) begin
        if (d) begin
          if ((w == 8 && q8.size() == 0) || (w == 2 && q2.size() == 0)) begin
            vectors++; errs++;
            $display("FAIL unexpected_done w%0d: got done=1 expected done=0 (cycle %0d)", w, cyc);
          end else begin
            if (w == 8) e = q8.pop_front(); else e = q2.pop_front();
            check($sformatf("diff_w%0d", w), {24'b0, df}, {24'b0, e.diff});
            check($sformatf("bout_w%0d", w), {31'b0, bo}, {31'b0, e.bout});
            check($sformatf("done_cycle_w%0d", w), cyc, e.cyc);
          end
        end else if (w == 8 && q8.size() > 0 && cyc > q8[0].cyc) begin
          check("done_timeout_w8", 32'd0, 32'd1);
          void'(q8.pop_front());
        end else if (w == 2 && q2.size() > 0 && cyc > q2[0].cyc) begin
          check("done_timeout_w2", 32'd0, 32'd1);
          void'(q2.pop_front());
        end
      end
    end
  endtask

  // One WIDTH=8 operation; optionally checks diff/bout hold the previous result.
  task automatic run8(input logic [7:0] x, input logic [7:0] y,
                      input logic chk_hold, input logic [7:0] hd, input logic hb);
    exp_t e;
    int   n;
    int   busyc;
    @(negedge clk);
    a8 = x; b8 = y; start8 = 1'b1;
    e.diff = x - y; e.bout = (x < y); e.cyc = cyc + 1 + 8;
    q8.push_back(e);
    @(negedge clk);
    start8 = 1'b0; a8 = ~x; b8 = ~y;
    n = 0; busyc = 0;
    while (!done8 && n < 30) begin
      if (busy8) busyc++;
      if (chk_hold) begin
        check("diff_hold", {24'b0, diff8}, {24'b0, hd});
        check("bout_hold", {31'b0, bout8}, {31'b0, hb});
      end
      @(negedge clk);
      n++;
    end
    check("busy_cycles", busyc, 8);
  endtask

  task automatic run2(input logic [1:0] x, input logic [1:0] y);
    exp_t e;
    int   n;
    @(negedge clk);
    a2 = x; b2 = y; start2 = 1'b1;
    e.diff = {6'b0, 2'(x - y)}; e.bout = (x < y); e.cyc = cyc + 1 + 2;
    q2.push_back(e);
    @(negedge clk);
    start2 = 1'b0; a2 = ~x; b2 = ~y;
    n = 0;
    while (!done2 && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int e0;
    exp_t e;
    logic [7:0] ta;
    logic [7:0] tb;
    fork
      monitor(8);
      monitor(2);
    join_none

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy8}, 32'd0);
    check("rst_done", {31'b0, done8}, 32'd0);
    check("rst_diff", {24'b0, diff8}, 32'd0);
    check("rst_bout", {31'b0, bout8}, 32'd0);
    rst = 1'b0;

    // Basic and boundary operands.
    run8(8'h5A, 8'h3C, 1'b0, 8'h00, 1'b0);
    run8(8'h00, 8'h01, 1'b0, 8'h00, 1'b0);
    run8(8'h80, 8'h80, 1'b0, 8'h00, 1'b0);

    // start held high with operands changing every cycle.
    @(negedge clk);
    e0 = cyc + 1;
    start8 = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ta = 8'(i * 37 + 5);
      tb = 8'(i * 91 + 3);
      a8 = ta; b8 = tb;
      if (i % 10 == 0) begin
        e.diff = ta - tb; e.bout = (ta < tb); e.cyc = e0 + i + 8;
        q8.push_back(e);
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    repeat (8) @(negedge clk);
    check("hold_start_all_done", q8.size(), 32'd0);

    // Asynchronous reset in the middle of RUN.
    run8(8'hC3, 8'h11, 1'b0, 8'h00, 1'b0);
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h22; start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("arst_busy", {31'b0, busy8}, 32'd0);
    check("arst_done", {31'b0, done8}, 32'd0);
    check("arst_diff", {24'b0, diff8}, 32'd0);
    check("arst_bout", {31'b0, bout8}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run8(8'hFF, 8'h0F, 1'b0, 8'h00, 1'b0);

    // Back-to-back with result stability check.
    run8(8'h10, 8'h20, 1'b0, 8'h00, 1'b0);
    run8(8'h20, 8'h10, 1'b1, 8'hF0, 1'b1);

    // WIDTH=2 exhaustive.
    for (int x = 0; x < 4; x++) begin
      for (int y = 0; y < 4; y++) begin
        run2(2'(x), 2'(y));
      end
    end

    repeat (4) @(negedge clk);
    check("q8_drained", q8.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
`default_nettype wire
